clkdiv_ctrl: RTL and testbench

- Runtime-reconfigurable clock-divider controller: owns the divider counter, accepts new division values over a valid/ready handshake, and applies them only at full-period boundaries, so divided_clk never has a runt or stretched half-period.
- Also starts and stops the divider cleanly.
- Sits between a config source (mode select, VGA pixel-rate switching) and logic consuming divided_clk or the tick enable.
- f_out = f_clk / (2*(div+1)); 50 MHz clk, div=0 gives 25 MHz.

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/clkdiv_core.sv | 40 ++++
 rtl/clkdiv_ctrl.sv | 158 +++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared state encoding, default widths and the falling-boundary helper for clkdiv_ctrl.
package clkdiv_pkg;

  localparam int CNT_W_DEF = 26;

  typedef logic [1:0] state_t;

  localparam state_t HALT      = 2'd0;
  localparam state_t RUN       = 2'd1;
  localparam state_t PEND      = 2'd2;
  localparam state_t STOP_WAIT = 2'd3;

  // Terminal count while the output is high: divided_clk is about to fall.
  function automatic logic falling_boundary(input logic tc, input logic dclk);
    return tc & dclk;
  endfunction

endpackage

// File: rtl/clkdiv_core.sv
// Divider datapath: up-counter, terminal-count compare, output toggle and tick pulse.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_zero,
  input  logic             hold,
  input  logic [CNT_W-1:0] div,
  output logic             divided_clk,
  output logic             tick,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_r;

  assign terminal = (cnt_r == div);

  // Counter advance, toggle on terminal count, park at zero/low while held.
  always_ff @(posedge clk) begin
    if (rst || hold) begin
      cnt_r       <= {CNT_W{1'b0}};
      divided_clk <= 1'b0;
      tick        <= 1'b0;
    end else if (terminal) begin
      cnt_r       <= {CNT_W{1'b0}};
      divided_clk <= ~divided_clk;
      tick        <= 1'b1;
    end else if (load_zero) begin
      cnt_r       <= {CNT_W{1'b0}};
      tick        <= 1'b0;
    end else begin
      cnt_r       <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      tick        <= 1'b0;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Runtime-reconfigurable clock divider controller; new divisors and stops take effect only
// at falling boundaries. Optional minimum-divisor check: define CLKDIV_MIN_CHECK_EN.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = {CNT_W{1'b0}}
`ifdef CLKDIV_MIN_CHECK_EN
  ,
  parameter logic [CNT_W-1:0] MIN_DIV     = {CNT_W{1'b0}}
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             divided_clk,
  output logic             tick,
  output logic [CNT_W-1:0] active_div,
  output logic             busy
`ifdef CLKDIV_MIN_CHECK_EN
  ,
  output logic             cfg_err
`endif
);

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] pend_div_r;
  logic             term_s;
  logic             fb_s;
  logic             accept_s;
  logic             bad_s;
  logic             hold_s;
  logic             load_zero_s;
  logic             take_s;
  logic             latch_s;
  logic             apply_s;

  assign fb_s     = falling_boundary(term_s, divided_clk);
  assign accept_s = cfg_valid && cfg_ready;

`ifdef CLKDIV_MIN_CHECK_EN
  logic cfg_err_r;
  assign bad_s   = (cfg_div < MIN_DIV);
  assign cfg_err = cfg_err_r;

  // A rejected handshake still consumes ready; flag it for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= accept_s && bad_s;
    end
  end
`else
  assign bad_s = 1'b0;
`endif

  // Next state and datapath strobes.
  always_comb begin
    state_nx_s  = state_r;
    hold_s      = 1'b0;
    load_zero_s = 1'b0;
    take_s      = 1'b0;
    latch_s     = 1'b0;
    apply_s     = 1'b0;
    case (state_r)
      HALT: begin
        hold_s = 1'b1;
        if (accept_s) begin
          take_s     = !bad_s;
          state_nx_s = HALT;
        end else if (run_en) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = HALT;
        end
      end
      RUN: begin
        if (accept_s) begin
          latch_s    = !bad_s;
          state_nx_s = bad_s ? RUN : PEND;
        end else if (!run_en) begin
          state_nx_s = STOP_WAIT;
        end else begin
          state_nx_s = RUN;
        end
      end
      PEND: begin
        if (fb_s) begin
          apply_s     = 1'b1;
          load_zero_s = 1'b1;
          state_nx_s  = run_en ? RUN : HALT;
        end else begin
          state_nx_s  = PEND;
        end
      end
      STOP_WAIT: begin
        // A returning run_en keeps the divider going, even on the boundary cycle itself.
        if (run_en) begin
          state_nx_s = RUN;
        end else if (fb_s) begin
          state_nx_s = HALT;
        end else begin
          state_nx_s = STOP_WAIT;
        end
      end
      default: begin
        hold_s     = 1'b1;
        state_nx_s = HALT;
      end
    endcase
  end

  // State, status flags and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= HALT;
      cfg_ready  <= 1'b1;
      busy       <= 1'b0;
      active_div <= DEFAULT_DIV;
      pend_div_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      cfg_ready  <= (state_nx_s == HALT) || (state_nx_s == RUN);
      busy       <= (state_nx_s == PEND) || (state_nx_s == STOP_WAIT);
      if (take_s) begin
        active_div <= cfg_div;
      end else if (apply_s) begin
        active_div <= pend_div_r;
      end else begin
        active_div <= active_div;
      end
      if (latch_s) begin
        pend_div_r <= cfg_div;
      end else begin
        pend_div_r <= pend_div_r;
      end
    end
  end

  clkdiv_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .load_zero   (load_zero_s),
    .hold        (hold_s),
    .div         (active_div),
    .divided_clk (divided_clk),
    .tick        (tick),
    .terminal    (term_s)
  );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed scenarios plus random traffic against a
// half-period countdown model of the divider.
module tb_clkdiv_ctrl;

  localparam int CNT_W = 26;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             divided_clk;
  logic             tick;
  logic [CNT_W-1:0] active_div;
  logic             busy;
`ifdef CLKDIV_MIN_CHECK_EN
  logic             cfg_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: running flag, output level, cycles left in this half period.
  bit m_running, m_level, m_tick, m_stop, m_has_pend, m_err;
  int m_left, m_div, m_pend;

  always #10 clk = ~clk;

  clkdiv_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (26'd0)
`ifdef CLKDIV_MIN_CHECK_EN
    ,
    .MIN_DIV     (26'd2)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_en      (run_en),
    .cfg_valid   (cfg_valid),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .divided_clk (divided_clk),
    .tick        (tick),
    .active_div  (active_div),
    .busy        (busy)
`ifdef CLKDIV_MIN_CHECK_EN
    ,
    .cfg_err     (cfg_err)
`endif
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ready, accept, bad, fall, was_pend, was_stop;
    ready = !m_has_pend && !m_stop;
    m_err = 1'b0;
    if (rst) begin
      m_running = 1'b0; m_level = 1'b0; m_tick = 1'b0; m_stop = 1'b0;
      m_has_pend = 1'b0; m_left = 0; m_div = 0; m_pend = 0;
      return;
    end
    accept = cfg_valid && ready;
    bad = 1'b0;
`ifdef CLKDIV_MIN_CHECK_EN
    bad   = accept && (int'(cfg_div) < 2);
    m_err = bad;
`endif
    if (!m_running) begin
      m_tick  = 1'b0;
      m_level = 1'b0;
      if (accept) begin
        if (!bad) m_div = int'(cfg_div);
      end else if (run_en) begin
        m_running = 1'b1;
        m_left    = m_div + 1;
      end
    end else begin
      was_pend = m_has_pend;
      was_stop = m_stop;
      m_left   = m_left - 1;
      m_tick   = (m_left == 0);
      fall     = m_tick && m_level;
      if (was_pend) begin
        if (fall) begin
          m_div      = m_pend;
          m_has_pend = 1'b0;
          if (!run_en) m_running = 1'b0;
        end
      end else if (was_stop) begin
        if (run_en) m_stop = 1'b0;
        else if (fall) begin
          m_stop    = 1'b0;
          m_running = 1'b0;
        end
      end else if (accept) begin
        if (!bad) begin
          m_has_pend = 1'b1;
          m_pend     = int'(cfg_div);
        end
      end else if (!run_en) begin
        m_stop = 1'b1;
      end
      if (m_tick) begin
        m_level = !m_level;
        m_left  = m_div + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("divided_clk", divided_clk, m_level);
    chk("tick", tick, m_tick);
    chk("active_div", active_div, m_div);
    chk("cfg_ready", cfg_ready, !m_has_pend && !m_stop);
    chk("busy", busy, m_has_pend || m_stop);
`ifdef CLKDIV_MIN_CHECK_EN
    chk("cfg_err", cfg_err, m_err);
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input int d);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(d);
    step();
    cfg_valid = 1'b0;
  endtask

  // Advance until the next edge is a falling boundary (bounded).
  task automatic to_fall_edge();
    for (int i = 0; i < 200; i++) begin
      if (m_running && m_level && m_left == 1) return;
      step();
    end
    n_tests++;
    n_fail++;
    $display("FAIL to_fall_edge: no falling boundary within 200 cycles");
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    steps(2);
    chk("reset_ready", cfg_ready, 1);
    rst = 1'b0;
    steps(2);
    // div=0: toggle every cycle
    run_en = 1'b1;
    steps(8);
    offer(4);
    steps(12);
    // new value offered during the high phase at div=4
    for (int i = 0; i < 20 && !(m_level && m_left == 3); i++) step();
    offer(9);
    steps(50);
    // accept landing exactly on a falling boundary at div=2
    offer(2);
    steps(30);
    to_fall_edge();
    offer(5);
    steps(30);
    // stop requested in the low phase at div=3
    offer(3);
    steps(20);
    for (int i = 0; i < 20 && m_level; i++) step();
    run_en = 1'b0;
    steps(20);
    chk("halted_low", divided_clk, 0);
    // reset while a value of 7 is pending
    run_en = 1'b1;
    steps(3);
    offer(7);
    step();
    rst = 1'b1;
    step();
    chk("rst_active_div", active_div, 0);
    rst = 1'b0;
    steps(10);
`ifdef CLKDIV_MIN_CHECK_EN
    offer(3);
    steps(20);
    offer(1);
    steps(10);
`endif
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(299) == 0);
      if ($urandom_range(39) == 0) run_en = !run_en;
      cfg_valid = ($urandom_range(7) == 0);
      cfg_div   = ($urandom_range(15) == 0) ? CNT_W'($urandom_range(20))
                                            : CNT_W'($urandom_range(6));
      step();
    end
    rst = 1'b0; cfg_valid = 1'b0;
    steps(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
